// File: rtl/pipelined_adder_pkg.sv
// Shared configuration helpers for the pipelined carry-select adder/subtractor.
package pipelined_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd32;
  localparam int unsigned DEFAULT_SEG   = 32'd8;

  function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned seg);
    return (seg != 32'd0) && ((width % seg) == 32'd0);
  endfunction

endpackage

// File: rtl/csel_segment.sv
// One SEG-bit carry-select slice: both carry-in candidates are precomputed.
// With OVF_FLAG_EN defined it also exposes the carry into its MSB.
module csel_segment
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] seg_a,
  input  logic [SEG-1:0] seg_b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
`ifdef OVF_FLAG_EN
  ,
  output logic           cmsb
`endif
);

  logic [SEG:0] sum0_s;
  logic [SEG:0] sum1_s;

  assign sum0_s = {1'b0, seg_a} + {1'b0, seg_b};
  assign sum1_s = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, 1'b1};

  // The late-arriving carry only drives this final select.
  always_comb begin
    if (ci) begin
      {co, s} = sum1_s;
    end else begin
      {co, s} = sum0_s;
    end
  end

`ifdef OVF_FLAG_EN
  assign cmsb = s[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];
`endif

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: stage k resolves segment k, global stall.
// Define OVF_FLAG_EN to add the registered signed-overflow output ovf.
module pipelined_csel_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSEG = calc_nseg(WIDTH, SEG);

  if (!width_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of SEG");
  end

  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;

  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;
  assign b_eff_s   = b ^ {WIDTH{sub}};
  assign c0_s      = sub | cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Operand-B bits still unresolved when entering this stage.
    localparam int unsigned RW = WIDTH - k * SEG;

    logic [WIDTH-1:0] src_word_s;
    logic [RW-1:0]    src_brem_s;
    logic             src_c_s;
    logic             src_v_s;
    logic [SEG-1:0]   seg_s;
    logic             co_s;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] word_q;
    logic             carry_q;
    logic             valid_q;
`ifdef OVF_FLAG_EN
    logic             cmsb_s;
`endif

    if (k == 0) begin : g_src
      assign src_word_s = a;
      assign src_brem_s = b_eff_s;
      assign src_c_s    = c0_s;
      assign src_v_s    = in_valid;
    end else begin : g_src
      assign src_word_s = g_stage[k-1].word_q;
      assign src_brem_s = g_stage[k-1].g_brem.brem_q;
      assign src_c_s    = g_stage[k-1].carry_q;
      assign src_v_s    = g_stage[k-1].valid_q;
    end

    csel_segment #(.SEG(SEG)) u_seg (
      .seg_a (src_word_s[k*SEG +: SEG]),
      .seg_b (src_brem_s[SEG-1:0]),
      .ci    (src_c_s),
      .s     (seg_s),
      .co    (co_s)
`ifdef OVF_FLAG_EN
      ,
      .cmsb  (cmsb_s)
`endif
    );

    // Word holds resolved sum bits below this segment and raw operand-A bits above it.
    always_comb begin
      word_d               = src_word_s;
      word_d[k*SEG +: SEG] = seg_s;
    end

    // Stage register: bubbles travel with the data and everything freezes on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        word_q  <= {WIDTH{1'b0}};
        carry_q <= 1'b0;
      end else if (advance_s) begin
        valid_q <= src_v_s;
        word_q  <= word_d;
        carry_q <= co_s;
      end
    end

    if (k < NSEG - 1) begin : g_brem
      logic [RW-SEG-1:0] brem_q;

      // Skew register for the operand-B segments later stages still need.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          brem_q <= {(RW-SEG){1'b0}};
        end else if (advance_s) begin
          brem_q <= src_brem_s[RW-1:SEG];
        end
      end
    end

`ifdef OVF_FLAG_EN
    if (k == NSEG - 1) begin : g_ovf
      logic ovf_q;

      // Signed overflow: carry into the MSB disagrees with carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance_s) begin
          ovf_q <= cmsb_s ^ co_s;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[NSEG-1].valid_q;
  assign sum       = g_stage[NSEG-1].word_q;
  assign cout      = g_stage[NSEG-1].carry_q;
`ifdef OVF_FLAG_EN
  assign ovf       = g_stage[NSEG-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder (default WIDTH=32, SEG=8).
// Build with OVF_FLAG_EN defined to also check the ovf output.
module tb_pipelined_csel_adder;

  localparam int NSEG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef OVF_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          age;
  } exp_t;

  exp_t mq[$];

  pipelined_csel_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
    logic [31:0] ye;
    ye = sb ? ~y : y;
    return {1'b0, x} + {1'b0, ye} + {32'd0, (sb ? 1'b1 : ci)};
  endfunction

  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
    logic [31:0] ye;
    logic [32:0] r;
    ye = sb ? ~y : y;
    r  = ref_add(x, y, ci, sb);
    return (x[31] == ye[31]) && (r[31] != x[31]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted operation ages one step per advancing cycle and is due after NSEG.
  always @(posedge clk or negedge rst_n) begin
    bit          have;
    bit          adv;
    exp_t        e;
    logic [32:0] r;
    if (!rst_n) begin
      mq.delete();
    end else begin
      have = (mq.size() > 0) && (mq[0].age >= NSEG);
      adv  = !have || out_ready;
      if (adv) begin
        if (have) void'(mq.pop_front());
        for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
        if (in_valid) begin
          r     = ref_add(a, b, cin, sub);
          e.s   = r[31:0];
          e.c   = r[32];
          e.o   = ref_ovf(a, b, cin, sub);
          e.age = 1;
          mq.push_back(e);
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic ev;
    #2;
    if (!rst_n) begin
      chk("out_valid_in_reset", out_valid, 1'b0);
    end else begin
      ev = (mq.size() > 0) && (mq[0].age >= NSEG);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || out_ready);
      if (ev) begin
        chk("sum", sum, mq[0].s);
        chk("cout", cout, mq[0].c);
`ifdef OVF_FLAG_EN
        chk("ovf", ovf, mq[0].o);
`endif
      end
    end
  end

  task automatic one(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb,
                     input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    chk("lit_latency", lat, 4);
    chk("lit_sum", sum, es);
    chk("lit_cout", cout, ec);
`ifdef OVF_FLAG_EN
    chk("lit_ovf", ovf, eo);
`else
    if (eo !== ref_ovf(x, y, ci, sb)) $display("note: ovf literal disagrees with model");
`endif
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
    int   n;
    logic acc;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    n = 0;
    do begin
      #1;
      acc = in_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 50);
    chk("send_accepted", acc, 1'b1);
  endtask

  initial begin
    logic [31:0] ra [6];
    logic [31:0] rb [6];
    logic        rc [6];
    logic        rs [6];
    logic [31:0] bx [6];
    logic [32:0] r;
    int          w;
    int          got;
    int          seen;
    int          mode;
    logic        pend;
    logic        acc;

    rst_n = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("model_add", ref_add(32'h1, 32'h1, 1'b0, 1'b0), 33'h0_0000_0002);
    chk("model_sub", ref_add(32'h10, 32'h20, 1'b0, 1'b1), 33'h0_FFFF_FFF0);
    chk("model_ovf", ref_ovf(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0), 1'b1);

    one(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    one(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    one(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Back-to-back streaming.
    @(negedge clk);
    a = 32'hFFFF_0006; b = 32'h1256_0006; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'hFEFE_F1EF; b = 32'hFEFE_F1EF;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    chk("b2b_sum0", sum, 32'h1255_000C);
    chk("b2b_cout0", cout, 1'b1);
    @(negedge clk);
    chk("b2b_valid1", out_valid, 1'b1);
    chk("b2b_sum1", sum, 32'hFDFD_E3DE);
    chk("b2b_cout1", cout, 1'b1);
    repeat (6) @(negedge clk);

    // Backpressure: six inputs, three-cycle stall once the first result is up.
    for (int i = 0; i < 6; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom); rs[i] = 1'($urandom);
      r = ref_add(ra[i], rb[i], rc[i], rs[i]);
      bx[i] = r[31:0];
    end
    fork
      begin
        for (int i = 0; i < 6; i++) send(ra[i], rb[i], rc[i], rs[i]);
        in_valid = 1'b0;
      end
      begin
        int sw;
        sw = 0;
        while (!out_valid && sw < 50) begin @(negedge clk); sw++; end
        out_ready = 1'b0;
        repeat (3) begin
          #1;
          chk("bp_in_ready", in_ready, 1'b0);
          chk("bp_sum_hold", sum, bx[0]);
          @(negedge clk);
        end
        out_ready = 1'b1;
        got = 0; sw = 0;
        while (got < 6 && sw < 100) begin
          #1;
          if (out_valid) begin
            chk("bp_order", sum, bx[got]);
            got++;
          end
          @(negedge clk);
          sw++;
        end
        chk("bp_count", got, 6);
      end
    join
    repeat (6) @(negedge clk);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h100 + 32'(i), 32'h3, 1'b0, 1'b0);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    chk("rst_pre_valid", out_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1 chk("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); #1; if (out_valid) seen++; end
    chk("rst_no_stale", seen, 0);

    // Randomized traffic with random backpressure; source holds unaccepted offers.
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        mode = $urandom_range(0, 3);
        case (mode)
          0: begin a = $urandom; b = $urandom; end
          1: begin a = 32'hFFFF_FFFF; b = 32'($urandom_range(0, 2)); end
          2: begin a = $urandom; b = a; end
          default: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(0, 255)); end
        endcase
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = in_valid && in_ready;
      pend = in_valid && !acc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_empty", mq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
